// File: rtl/cache_fill_ahb.sv
// AHB-Lite burst-read master that refills one cache line into the cache data RAM.
// Optional critical-word-first WRAP bursts when CACHE_FILL_WRAP_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a fill request
// ADDR   | issuing address phases of the burst
// DRAIN  | all addresses issued, waiting for the final data beat
// ERR    | ERROR response seen, waiting for its second cycle
// FIN    | one-cycle completion pulse
module cache_fill_ahb #(
    parameter int          LINE_WORDS = 4,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011,
    parameter int          IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic              i_hclk,
    input  logic              i_hnreset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_en,
    output logic              o_hsel,
    output logic [31:0]       o_haddr,
    output logic              o_hwrite,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic [3:0]        o_hprot,
    output logic [1:0]        o_htrans,
    output logic              o_hmastlock,
    output logic              o_hready_i,
    output logic [31:0]       o_hwdata,
    input  logic              i_hready,
    input  logic              i_hresp,
    input  logic [31:0]       i_hrdata,
    output logic              o_ram_we,
    output logic [IDX_W-1:0]  o_ram_widx,
    output logic [31:0]       o_ram_wdata
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DRAIN, S_ERR, S_FIN} state_t;

    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;
    localparam logic [1:0]  HT_SEQ    = 2'b11;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    state_t           state;
    logic [31:0]      base_q;
    logic [IDX_W-1:0] offset_q;
    logic [IDX_W-1:0] beats_left;
    logic [IDX_W-1:0] data_idx;
    logic             dvalid;
    logic [1:0]       htrans_q;
    logic [IDX_W-1:0] start_off;
    logic [IDX_W-1:0] offset_nxt;
    logic [31:0]      line_base;
    logic             data_ok;
    logic             data_err;

`ifdef CACHE_FILL_WRAP_EN
    assign start_off = i_addr[IDX_W+1:2];
    assign o_hburst  = (LINE_WORDS == 16) ? 3'b110 : (LINE_WORDS == 8) ? 3'b100 : 3'b010;
`else
    assign start_off = '0;
    assign o_hburst  = (LINE_WORDS == 16) ? 3'b111 : (LINE_WORDS == 8) ? 3'b101 : 3'b011;
`endif

    // offset wraps naturally at IDX_W bits, which is what WRAP bursts need
    assign offset_nxt = offset_q + IDX_W'(1);
    assign line_base  = i_addr & ~LINE_MASK;
    assign data_ok    = dvalid && i_hready && !i_hresp;
    assign data_err   = dvalid && i_hresp;

    assign o_hwrite    = 1'b0;
    assign o_hsize     = 3'b010;
    assign o_hprot     = HPROT_VAL;
    assign o_hmastlock = 1'b0;
    assign o_hwdata    = 32'h0;
    assign o_hready_i  = i_hready;
    // first ERROR cycle must cancel the pending address phase immediately
    assign o_htrans    = data_err ? HT_IDLE : htrans_q;
    assign o_ram_we    = data_ok;
    assign o_ram_widx  = data_idx;
    assign o_ram_wdata = i_hrdata;

    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state      <= S_IDLE;
            base_q     <= '0;
            offset_q   <= '0;
            beats_left <= '0;
            data_idx   <= '0;
            dvalid     <= 1'b0;
            htrans_q   <= HT_IDLE;
            o_haddr    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_en       <= 1'b0;
            o_hsel     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        base_q     <= line_base;
                        offset_q   <= start_off;
                        beats_left <= IDX_W'(LINE_WORDS - 1);
                        o_haddr    <= line_base | 32'({start_off, 2'b00});
                        htrans_q   <= HT_NONSEQ;
                        o_en       <= 1'b1;
                        o_hsel     <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (data_err) begin
                        dvalid   <= 1'b0;
                        htrans_q <= HT_IDLE;
                        o_en     <= 1'b0;
                        o_hsel   <= 1'b0;
                        state    <= S_ERR;
                    end else if (i_hready) begin
                        dvalid   <= 1'b1;
                        data_idx <= offset_q;
                        offset_q <= offset_nxt;
                        o_haddr  <= base_q | 32'({offset_nxt, 2'b00});
                        if (beats_left == '0) begin
                            htrans_q <= HT_IDLE;
                            o_en     <= 1'b0;
                            o_hsel   <= 1'b0;
                            state    <= S_DRAIN;
                        end else begin
                            beats_left <= beats_left - IDX_W'(1);
                            htrans_q   <= HT_SEQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (data_err) begin
                        dvalid <= 1'b0;
                        state  <= S_ERR;
                    end else if (data_ok) begin
                        dvalid <= 1'b0;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_FIN;
                    end
                end
                S_ERR: begin
                    if (i_hready) begin
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ahb.sv
// Self-checking bench for cache_fill_ahb: behavioural AHB slave plus a line-fill reference model.
module tb_cache_fill_ahb;
    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic          i_hclk = 1'b0;
    logic          i_hnreset = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          o_busy, o_done, o_err, o_en, o_hsel, o_hwrite, o_hmastlock, o_hready_i;
    logic [31:0]   o_haddr, o_hwdata, o_ram_wdata;
    logic [2:0]    o_hsize, o_hburst;
    logic [3:0]    o_hprot;
    logic [1:0]    o_htrans;
    logic          i_hready = 1'b1;
    logic          i_hresp = 1'b0;
    logic [31:0]   i_hrdata = '0;
    logic          o_ram_we;
    logic [IW-1:0] o_ram_widx;

    int n_cmp = 0;
    int n_fail = 0;

    cache_fill_ahb #(.LINE_WORDS(LW), .HPROT_VAL(4'b0011)) dut (
        .i_hclk(i_hclk), .i_hnreset(i_hnreset), .i_req(i_req), .i_addr(i_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_en(o_en), .o_hsel(o_hsel),
        .o_haddr(o_haddr), .o_hwrite(o_hwrite), .o_hsize(o_hsize), .o_hburst(o_hburst),
        .o_hprot(o_hprot), .o_htrans(o_htrans), .o_hmastlock(o_hmastlock),
        .o_hready_i(o_hready_i), .o_hwdata(o_hwdata), .i_hready(i_hready),
        .i_hresp(i_hresp), .i_hrdata(i_hrdata), .o_ram_we(o_ram_we),
        .o_ram_widx(o_ram_widx), .o_ram_wdata(o_ram_wdata)
    );

    always #5 i_hclk = ~i_hclk;

    // reference model: where beat k of a line fill goes
    function automatic int start_word(input logic [31:0] a);
`ifdef CACHE_FILL_WRAP_EN
        return int'((a / 4) % LW);
`else
        return 0;
`endif
    endfunction

    function automatic int exp_idx(input logic [31:0] a, input int k);
        return (start_word(a) + k) % LW;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
        logic [31:0] base;
        base = a - (a % (LW * 4));
        return base + 32'(exp_idx(a, k) * 4);
    endfunction

    function automatic logic [2:0] exp_hburst();
`ifdef CACHE_FILL_WRAP_EN
        return (LW == 4) ? 3'b010 : (LW == 8) ? 3'b100 : 3'b110;
`else
        return (LW == 4) ? 3'b011 : (LW == 8) ? 3'b101 : 3'b111;
`endif
    endfunction

    // observations of the last fill
    logic [31:0] q_addr[$];
    logic [1:0]  q_trans[$];
    int          q_widx[$];
    logic [31:0] q_wdata[$];
    logic [31:0] q_sent[$];
    int n_en, done_cnt, first_nonseq, hold_viol, const_viol, last_we_cyc, done_cyc;
    logic err_flag;
    logic [1:0] err_trans;
    bit timed_out;

    // drives one fill through a behavioural slave and records what the DUT did
    task automatic do_fill(input logic [31:0] a, input bit keep_req, input int err_beat,
                           input int wait_beat, input int wait_len, input bit rnd_waits);
        bit pend, fin, prev_wait, err_now, acc;
        int dbeat, eph, waits_done, cyc;
        logic [31:0] prev_addr;
        logic [1:0] prev_trans;
        q_addr.delete(); q_trans.delete(); q_widx.delete(); q_wdata.delete(); q_sent.delete();
        n_en = 0; done_cnt = 0; first_nonseq = -1; hold_viol = 0; const_viol = 0;
        last_we_cyc = -1; done_cyc = -1; err_flag = 1'b0; err_trans = 2'bxx; timed_out = 0;
        pend = 0; fin = 0; prev_wait = 0; dbeat = 0; eph = 0; waits_done = 0; cyc = 0;
        prev_addr = '0; prev_trans = '0;
        @(posedge i_hclk); #1;
        i_req = 1'b1; i_addr = a; i_hready = 1'b1; i_hresp = 1'b0;
        @(posedge i_hclk); #1;
        i_req = keep_req;
        while (!fin && cyc < 300) begin
            i_hresp = 1'b0; i_hready = 1'b1; i_hrdata = $urandom; err_now = 0;
            if (pend && dbeat == err_beat && eph == 0) begin
                i_hready = 1'b0; i_hresp = 1'b1; eph = 1; err_now = 1;
            end else if (eph == 1) begin
                i_hready = 1'b1; i_hresp = 1'b1; eph = 2;
            end else if (pend && dbeat == wait_beat && waits_done < wait_len) begin
                i_hready = 1'b0; waits_done++;
            end else if (pend && rnd_waits && $urandom_range(0, 2) == 0) begin
                i_hready = 1'b0;
            end
            @(negedge i_hclk);
            if (err_now) err_trans = o_htrans;
            if (prev_wait && !i_hresp && (o_haddr !== prev_addr || o_htrans !== prev_trans))
                hold_viol++;
            prev_wait = (o_htrans != 2'b00) && !i_hready;
            prev_addr = o_haddr; prev_trans = o_htrans;
            if (o_en) n_en++;
            if (o_hready_i !== i_hready || o_hwrite !== 1'b0 || o_hsize !== 3'b010 ||
                o_hprot !== 4'b0011 || o_hmastlock !== 1'b0 || o_hwdata !== 32'h0 ||
                o_hburst !== exp_hburst() || o_hsel !== o_en)
                const_viol++;
            acc = (o_htrans != 2'b00) && i_hready;
            if (acc) begin
                q_addr.push_back(o_haddr); q_trans.push_back(o_htrans);
                if (first_nonseq < 0) first_nonseq = cyc;
            end
            if (o_ram_we) begin
                q_widx.push_back(int'(o_ram_widx)); q_wdata.push_back(o_ram_wdata);
                last_we_cyc = cyc;
            end
            if (pend && i_hready && !i_hresp) begin
                q_sent.push_back(i_hrdata); dbeat++;
            end
            if (i_hready) pend = acc;
            if (o_done) begin
                done_cnt++; err_flag = o_err; done_cyc = cyc; fin = 1;
            end else begin
                @(posedge i_hclk); #1;
                cyc++;
            end
        end
        if (!fin) timed_out = 1;
        i_hresp = 1'b0; i_hready = 1'b1;
    endtask

    task automatic test_reset();
        i_hnreset = 1'b0;
        repeat (3) @(posedge i_hclk);
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_err, o_en, o_hsel, o_htrans, o_ram_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {o_busy, o_done, o_err, o_en, o_hsel, o_htrans, o_ram_we});
        end
        n_cmp++;
        if (o_haddr !== 32'h0) begin
            n_fail++; $display("FAIL reset_haddr got %h want 0", o_haddr);
        end
        n_cmp++;
        if (o_hburst !== exp_hburst()) begin
            n_fail++; $display("FAIL reset_hburst got %b want %b", o_hburst, exp_hburst());
        end
        @(negedge i_hclk);
        i_hnreset = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        a = 32'h1000_0014;
        do_fill(a, 0, -1, -1, 0, 0);
        n_cmp++;
        if (timed_out) begin n_fail++; $display("FAIL zw_timeout got no done want done"); end
        n_cmp++;
        if (q_addr.size() != LW) begin
            n_fail++; $display("FAIL zw_nbeats got %0d want %0d", q_addr.size(), LW);
        end
        for (int k = 0; k < q_addr.size() && k < LW; k++) begin
            n_cmp++;
            if (q_addr[k] !== exp_addr(a, k) || q_trans[k] !== ((k == 0) ? 2'b10 : 2'b11)) begin
                n_fail++;
                $display("FAIL zw_addr[%0d] got %h/%b want %h/%b", k, q_addr[k], q_trans[k],
                         exp_addr(a, k), (k == 0) ? 2'b10 : 2'b11);
            end
        end
        n_cmp++;
        if (q_widx.size() != LW) begin
            n_fail++; $display("FAIL zw_nwrites got %0d want %0d", q_widx.size(), LW);
        end
        for (int k = 0; k < q_widx.size() && k < q_sent.size(); k++) begin
            n_cmp++;
            if (q_widx[k] != exp_idx(a, k) || q_wdata[k] !== q_sent[k]) begin
                n_fail++;
                $display("FAIL zw_write[%0d] got idx %0d data %h want idx %0d data %h",
                         k, q_widx[k], q_wdata[k], exp_idx(a, k), q_sent[k]);
            end
        end
        n_cmp++;
        if (err_flag !== 1'b0 || done_cyc != last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL zw_done got err %b cyc %0d want err 0 cyc %0d",
                     err_flag, done_cyc, last_we_cyc + 1);
        end
        n_cmp++;
        if (n_en != LW || first_nonseq != 0) begin
            n_fail++;
            $display("FAIL zw_en got en %0d first %0d want en %0d first 0", n_en, first_nonseq, LW);
        end
        n_cmp++;
        if (const_viol != 0) begin
            n_fail++; $display("FAIL zw_const got %0d bad cycles want 0", const_viol);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        a = 32'h1000_0024;
        do_fill(a, 0, -1, 2, 2, 0);
        n_cmp++;
        if (timed_out || q_widx.size() != LW) begin
            n_fail++; $display("FAIL ws_nwrites got %0d want %0d", q_widx.size(), LW);
        end
        for (int k = 0; k < q_widx.size() && k < q_sent.size(); k++) begin
            n_cmp++;
            if (q_widx[k] != exp_idx(a, k) || q_wdata[k] !== q_sent[k]) begin
                n_fail++;
                $display("FAIL ws_write[%0d] got idx %0d data %h want idx %0d data %h",
                         k, q_widx[k], q_wdata[k], exp_idx(a, k), q_sent[k]);
            end
        end
        n_cmp++;
        if (hold_viol != 0) begin
            n_fail++; $display("FAIL ws_hold got %0d changes want 0", hold_viol);
        end
        n_cmp++;
        if (q_addr.size() != LW || q_addr[LW-1] !== exp_addr(a, LW - 1)) begin
            n_fail++; $display("FAIL ws_addr got %0d beats want %0d", q_addr.size(), LW);
        end
    endtask

    task automatic test_error();
        logic [31:0] a;
        a = 32'h3000_0040;
        do_fill(a, 0, 1, -1, 0, 0);
        n_cmp++;
        if (timed_out || done_cnt != 1 || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL err_done got done %0d err %b want done 1 err 1", done_cnt, err_flag);
        end
        n_cmp++;
        if (err_trans !== 2'b00) begin
            n_fail++; $display("FAIL err_htrans got %b want 00", err_trans);
        end
        n_cmp++;
        if (q_widx.size() != 1 || q_widx[0] != exp_idx(a, 0) || q_wdata[0] !== q_sent[0]) begin
            n_fail++; $display("FAIL err_writes got %0d want 1 at idx %0d", q_widx.size(), exp_idx(a, 0));
        end
        n_cmp++;
        if (q_addr.size() != 2) begin
            n_fail++; $display("FAIL err_nbeats got %0d want 2", q_addr.size());
        end
        @(negedge i_hclk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_en !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_after got busy %b en %b done %b want 0 0 0", o_busy, o_en, o_done);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int eb, nw, na;
        for (int it = 0; it < 12; it++) begin
            a = $urandom;
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            do_fill(a, 0, eb, -1, 0, 1);
            nw = (eb < 0) ? LW : eb;
            na = (eb < 0) ? LW : ((eb + 1 < LW) ? eb + 1 : LW);
            n_cmp++;
            if (timed_out || err_flag !== (eb >= 0) || q_widx.size() != nw || q_addr.size() != na) begin
                n_fail++;
                $display("FAIL rnd%0d_shape got err %b writes %0d beats %0d want err %b writes %0d beats %0d",
                         it, err_flag, q_widx.size(), q_addr.size(), eb >= 0, nw, na);
            end
            for (int k = 0; k < q_addr.size() && k < LW; k++) begin
                n_cmp++;
                if (q_addr[k] !== exp_addr(a, k)) begin
                    n_fail++; $display("FAIL rnd%0d_addr[%0d] got %h want %h", it, k, q_addr[k], exp_addr(a, k));
                end
            end
            for (int k = 0; k < q_widx.size() && k < q_sent.size(); k++) begin
                n_cmp++;
                if (q_widx[k] != exp_idx(a, k) || q_wdata[k] !== q_sent[k]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_write[%0d] got idx %0d data %h want idx %0d data %h",
                             it, k, q_widx[k], q_wdata[k], exp_idx(a, k), q_sent[k]);
                end
            end
            n_cmp++;
            if (hold_viol != 0 || const_viol != 0) begin
                n_fail++; $display("FAIL rnd%0d_hold got %0d/%0d want 0/0", it, hold_viol, const_viol);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0, a1;
        a0 = 32'h4000_1238;
        a1 = 32'h5000_00a4;
        do_fill(a0, 1, -1, -1, 0, 0);
        n_cmp++;
        if (timed_out || q_widx.size() != LW || q_addr[0] !== exp_addr(a0, 0)) begin
            n_fail++; $display("FAIL b2b_first got %0d writes want %0d", q_widx.size(), LW);
        end
        do_fill(a1, 0, -1, -1, 0, 0);
        n_cmp++;
        if (timed_out || first_nonseq != 0) begin
            n_fail++; $display("FAIL b2b_start got first beat at %0d want 0", first_nonseq);
        end
        for (int k = 0; k < q_addr.size() && k < LW; k++) begin
            n_cmp++;
            if (q_addr[k] !== exp_addr(a1, k)) begin
                n_fail++; $display("FAIL b2b_addr[%0d] got %h want %h", k, q_addr[k], exp_addr(a1, k));
            end
        end
        n_cmp++;
        if (q_widx.size() != LW || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got %0d writes err %b want %0d err 0", q_widx.size(), err_flag, LW);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(posedge i_hclk); #1;
        i_req = 1'b1; i_addr = 32'h6000_0010; i_hready = 1'b1; i_hresp = 1'b0;
        @(posedge i_hclk); #1;
        i_req = 1'b0;
        repeat (2) @(posedge i_hclk);
        @(negedge i_hclk);
        i_hnreset = 1'b0;
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_err, o_en, o_hsel, o_htrans, o_ram_we} !== 8'h00 || o_haddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got %b haddr %h want 00000000 haddr 0",
                     {o_busy, o_done, o_err, o_en, o_hsel, o_htrans, o_ram_we}, o_haddr);
        end
        repeat (2) @(negedge i_hclk);
        i_hnreset = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_hclk);
            if (o_done || o_ram_we || o_busy || o_en) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
